// File: rtl/lvt_scan_pkg.sv
// Shared definitions for the LVT scan harness host and harness:
// FSM state encoding and the serial frame / read-back length helpers.
package lvt_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_SETTLE = 3'd2,
    S_PUSH   = 3'd3,
    S_WAIT   = 3'd4,
    S_RECV   = 3'd5,
    S_RESP   = 3'd6
  } scan_state_e;

  // Request frame: {en, wdata, addr} for all ports.
  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned depth,
                                            input int unsigned ports);
    return ports + ports * width + ports * $clog2(depth);
  endfunction

  function automatic int unsigned rdata_len(input int unsigned width,
                                            input int unsigned ports);
    return ports * width;
  endfunction

  function automatic int unsigned max_u(input int unsigned a,
                                        input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parameterised shift register: parallel load or MSB-first serial shift,
// with serial in at the LSB, serial out from the MSB and parallel out.
module scan_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic         ser_out,
  output logic [W-1:0] par_out
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Load takes priority over shift.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[W-2:0], ser_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign ser_out = data_q[W-1];
  assign par_out = data_q;

endmodule

// File: rtl/lvt_scan_host.sv
// Host end of the LVT scan harness serial protocol: serialises one parallel
// multi-port request onto d, pulses push, then deserialises q into read data.
module lvt_scan_host
  import lvt_scan_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned DEPTH      = 512,
  parameter  int unsigned PORTS      = 2,
  parameter  int unsigned SETTLE_CYC = 8,
  parameter  int unsigned Q_LAT      = 4,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PORTS*AW-1:0]    req_addr,
  input  logic [PORTS*WIDTH-1:0] req_wdata,
  input  logic [PORTS-1:0]       req_en,
  output logic                   d,
  output logic                   push,
  input  logic                   q,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PORTS*WIDTH-1:0] rsp_rdata
);

  localparam int unsigned N  = frame_len(WIDTH, DEPTH, PORTS);
  localparam int unsigned M  = rdata_len(WIDTH, PORTS);
  localparam int unsigned CW = $clog2(max_u(max_u(N, M), max_u(SETTLE_CYC, Q_LAT)) + 1);
  // WAIT spans Q_LAT-1 cycles; with Q_LAT==1 it is skipped entirely.
  localparam int unsigned WAIT_LOAD = (Q_LAT > 1) ? (Q_LAT - 2) : 0;

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, push_q, rsp_valid_q;
  logic          frame_load, frame_shift, rd_shift;
  logic [N-1:0]  frame_par_unused;
  logic          rd_msb_unused;

  // Next-state, shared down-counter and shift-register controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_load  = 1'b0;
    frame_shift = 1'b0;
    rd_shift    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          frame_load = 1'b1;
          cnt_d      = CW'(N - 1);
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        frame_shift = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = CW'(SETTLE_CYC - 1);
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_PUSH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PUSH: begin
        if (Q_LAT > 1) begin
          cnt_d   = CW'(WAIT_LOAD);
          state_d = S_WAIT;
        end else begin
          cnt_d   = CW'(M - 1);
          state_d = S_RECV;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(M - 1);
          state_d = S_RECV;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RECV: begin
        rd_shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      push_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == S_IDLE);
      push_q      <= (state_d == S_PUSH);
      rsp_valid_q <= (state_d == S_RESP);
    end
  end

  // Zeros shift in behind the frame, so d falls back to 0 once SEND ends.
  scan_shift_reg #(
    .W (N)
  ) u_frame (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (frame_load),
    .load_data ({req_en, req_wdata, req_addr}),
    .shift_en  (frame_shift),
    .ser_in    (1'b0),
    .ser_out   (d),
    .par_out   (frame_par_unused)
  );

  scan_shift_reg #(
    .W (M)
  ) u_rdata (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ({M{1'b0}}),
    .shift_en  (rd_shift),
    .ser_in    (q),
    .ser_out   (rd_msb_unused),
    .par_out   (rsp_rdata)
  );

  assign req_ready = req_ready_q;
  assign push      = push_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_lvt_scan_host.sv
// Directed and randomised bench for lvt_scan_host with a cycle-offset
// reference model of the serial frame, push strobe and read-back word.
module tb_lvt_scan_host;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned PORTS      = 2;
  localparam int unsigned SETTLE_CYC = 3;
  localparam int unsigned Q_LAT      = 2;
  localparam int unsigned AW         = 3;
  localparam int unsigned N          = PORTS * (1 + WIDTH + AW);
  localparam int unsigned M          = PORTS * WIDTH;
  localparam int unsigned P_OFF      = N + SETTLE_CYC + 1;
  localparam int unsigned Q_OFF      = P_OFF + Q_LAT;
  localparam int unsigned T_OFF      = N + SETTLE_CYC + Q_LAT + M + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [PORTS*AW-1:0]    req_addr;
  logic [PORTS*WIDTH-1:0] req_wdata;
  logic [PORTS-1:0]       req_en;
  logic                   d;
  logic                   push;
  logic                   q;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [PORTS*WIDTH-1:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  lvt_scan_host #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .PORTS      (PORTS),
    .SETTLE_CYC (SETTLE_CYC),
    .Q_LAT      (Q_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_en    (req_en),
    .d         (d),
    .push      (push),
    .q         (q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit into the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
  endtask

  // Full transaction: accept, check every cycle against the model, drive q,
  // then hold the response for `hold` cycles before taking it.
  task automatic run_txn(input logic [1:0] en, input logic [7:0] wd,
                         input logic [5:0] ad, input logic [7:0] rd, input int hold);
    logic [31:0] fr;
    fr = (32'(en) << (PORTS * WIDTH + PORTS * AW)) | (32'(wd) << (PORTS * AW)) | 32'(ad);
    wait_ready();
    req_valid = 1'b1;
    req_en    = en;
    req_wdata = wd;
    req_addr  = ad;
    step();
    req_valid = 1'b0;
    req_en    = 2'($urandom);
    req_wdata = 8'($urandom);
    req_addr  = 6'($urandom);
    for (int c = 1; c <= int'(T_OFF); c++) begin
      if (c <= int'(N)) check("d_bit", 32'(d), (fr >> (N - c)) & 32'd1);
      else              check("d_idle", 32'(d), 32'd0);
      check("push", 32'(push), 32'(c == int'(P_OFF)));
      check("rsp_valid", 32'(rsp_valid), 32'(c == int'(T_OFF)));
      if (c < int'(T_OFF)) check("req_ready_busy", 32'(req_ready), 32'd0);
      if (c >= int'(Q_OFF) && c < int'(Q_OFF + M))
        q = 1'((32'(rd) >> (int'(M) - 1 - (c - int'(Q_OFF)))) & 32'd1);
      else
        q = 1'($urandom);
      if (c != int'(T_OFF)) step();
    end
    check("rsp_rdata", 32'(rsp_rdata), 32'(rd));
    for (int h = 0; h < hold; h++) begin
      step();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", 32'(rsp_rdata), 32'(rd));
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_ready", 32'(req_ready), 32'd1);
    check("done_rdata", 32'(rsp_rdata), 32'(rd));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_en    = '0;
    req_wdata = '0;
    req_addr  = '0;
    q         = 1'b0;
    rsp_ready = 1'b0;

    // Reset for three cycles, then release.
    step(); step(); step();
    check("rst_d", 32'(d), 32'd0);
    check("rst_push", 32'(push), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_d_after", 32'(d), 32'd0);
    check("rst_push_after", 32'(push), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);

    // Frame order, push timing, read-back and backpressure.
    run_txn(2'b10, 8'hA5, 6'b101_011, 8'h3C, 5);
    // Consumer already ready when the response appears.
    run_txn(2'b01, 8'h5A, 6'b010_110, 8'hC3, 0);

    // Reset in the middle of SEND.
    wait_ready();
    req_valid = 1'b1;
    req_en    = 2'b11;
    req_wdata = 8'hFF;
    req_addr  = 6'h3F;
    step();
    req_valid = 1'b0;
    for (int c = 1; c < 8; c++) step();
    rst_n = 1'b0;
    #1;
    check("mid_d", 32'(d), 32'd0);
    check("mid_push", 32'(push), 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("mid_push_hold", 32'(push), 32'd0);
      check("mid_d_hold", 32'(d), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < int'(T_OFF); c++) begin
      step();
      check("post_rst_push", 32'(push), 32'd0);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
    end
    run_txn(2'b10, 8'hA5, 6'b101_011, 8'h3C, 1);

    // Randomised transactions.
    for (int t = 0; t < 4; t++) begin
      run_txn(2'($urandom), 8'($urandom), 6'($urandom), 8'($urandom),
              int'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
